crossover_signal_gen: RTL and testbench

// Downstream consumer of the Preprocessor SMA/second-moment outputs. Detects fast/slow SMA crossovers with
// a hysteresis band and gates them on a variance limit derived from sqr_mean. Emits BUY/SELL events over a

---
 rtl/trade_pkg.sv | 31 +++
 rtl/crossover_signal_gen_vol_gate.sv | 40 ++++
 rtl/crossover_signal_gen.sv | 142 ++++++++++++++
 tb/tb_crossover_signal_gen.sv | 429 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/trade_pkg.sv
// Shared types for the crossover signal path and the order stage that consumes its events.
package trade_pkg;

  typedef enum logic [1:0] {
    UNKNOWN = 2'd0,
    ABOVE   = 2'd1,
    BELOW   = 2'd2
  } regime_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TRACK    = 2'd1,
    EMIT     = 2'd2,
    COOLDOWN = 2'd3
  } sig_state_e;

  localparam logic SIDE_BUY  = 1'b1;
  localparam logic SIDE_SELL = 1'b0;

  // Outside the band the regime follows the sign; inside it the old regime (even UNKNOWN) holds.
  function automatic regime_e next_regime(input regime_e cur, input logic above, input logic below);
    if (above) return ABOVE;
    if (below) return BELOW;
    return cur;
  endfunction

  function automatic logic is_crossing(input regime_e prev, input regime_e nxt);
    return ((prev == BELOW) && (nxt == ABOVE)) || ((prev == ABOVE) && (nxt == BELOW));
  endfunction

endpackage

// File: rtl/crossover_signal_gen_vol_gate.sv
// Variance estimate sqr_mean - slow^2, clamped at zero, registered on each valid sample.
module vol_gate #(
  parameter int DATA_WIDTH = 8,
  parameter int VAR_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  vld_i,
  input  logic [DATA_WIDTH-1:0] slow_i,
  input  logic [VAR_WIDTH-1:0]  sqr_mean_i,
  output logic [VAR_WIDTH-1:0]  var_o
);

  localparam int PW = 2 * DATA_WIDTH;
  localparam int EW = ((VAR_WIDTH > PW) ? VAR_WIDTH : PW) + 1;

  logic [PW-1:0]        sq;
  logic [EW-1:0]        sub;
  logic [VAR_WIDTH-1:0] var_d, var_q;

  assign sq  = PW'(slow_i) * PW'(slow_i);
  assign sub = EW'(sqr_mean_i) - EW'(sq);

  // A non-negative result never exceeds sqr_mean, so truncation to VAR_WIDTH is lossless.
  always_comb begin
    var_d = sub[VAR_WIDTH-1:0];
    if (sub[EW-1]) var_d = '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      var_q <= '0;
    end else if (vld_i) begin
      var_q <= var_d;
    end
  end

  assign var_o = var_q;

endmodule

// File: rtl/crossover_signal_gen.sv
// Fast/slow SMA crossover detector with hysteresis, volatility gate, valid/ready event output
// and a sample-counted cooldown. Event appears two edges after the crossing sample is presented.
module crossover_signal_gen #(
  parameter int                   DATA_WIDTH = 8,
  parameter int                   VAR_WIDTH  = 16,
  parameter int                   HYST       = 2,
  parameter int                   COOLDOWN   = 16,
  parameter logic [VAR_WIDTH-1:0] VOL_LIMIT  = 'h0400
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] sma_fast,
  input  logic [DATA_WIDTH-1:0] sma_slow,
  input  logic [VAR_WIDTH-1:0]  sqr_mean,
  input  logic [DATA_WIDTH-1:0] price,
  output logic                  sig_valid,
  input  logic                  sig_ready,
  output logic                  sig_side,
  output logic [DATA_WIDTH-1:0] sig_price,
  output logic [7:0]            dropped_cnt
);

  import trade_pkg::*;

  localparam int HEFF = (HYST == 0) ? 1 : HYST;
  localparam int CW   = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  // Band edges one bit wider than diff so a large HYST cannot wrap.
  localparam logic signed [DATA_WIDTH+1:0] H_POS = (DATA_WIDTH + 2)'(HEFF);
  localparam logic signed [DATA_WIDTH+1:0] H_NEG = -H_POS;

  logic signed [DATA_WIDTH:0]   diff_d, diff_q;
  logic signed [DATA_WIDTH+1:0] diff_x;
  logic [DATA_WIDTH-1:0]        price_q;
  logic                         s1_vld_q;
  logic [VAR_WIDTH-1:0]         var_q;

  assign diff_d = $signed({1'b0, sma_fast}) - $signed({1'b0, sma_slow});

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      diff_q   <= '0;
      price_q  <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= in_valid;
      if (in_valid) begin
        diff_q  <= diff_d;
        price_q <= price;
      end
    end
  end

  vol_gate #(
    .DATA_WIDTH (DATA_WIDTH),
    .VAR_WIDTH  (VAR_WIDTH)
  ) u_vol_gate (
    .clk        (clk),
    .rst        (rst),
    .vld_i      (in_valid),
    .slow_i     (sma_slow),
    .sqr_mean_i (sqr_mean),
    .var_o      (var_q)
  );

  regime_e               regime_q, regime_d;
  sig_state_e            state_q;
  logic [CW-1:0]         cnt_q;
  logic                  sig_valid_q, sig_side_q;
  logic [DATA_WIDTH-1:0] sig_price_q;
  logic [7:0]            dropped_q, dropped_d;
  logic                  crossing, var_ok, drop, xfer;

  always_comb begin
    diff_x   = {diff_q[DATA_WIDTH], diff_q};
    regime_d = regime_q;
    if (s1_vld_q) regime_d = next_regime(regime_q, diff_x >= H_POS, diff_x <= H_NEG);
    crossing = is_crossing(regime_q, regime_d);
    var_ok   = (var_q <= VOL_LIMIT);
    xfer     = sig_valid_q && sig_ready;
    // Any crossing that cannot become an event is counted, whatever the reason.
    drop     = crossing && ((state_q == trade_pkg::EMIT) ||
                            (state_q == trade_pkg::COOLDOWN) ||
                            ((state_q == trade_pkg::TRACK) && !var_ok));
    dropped_d = dropped_q;
    if (drop && (dropped_q != 8'hFF)) dropped_d = dropped_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= trade_pkg::IDLE;
      regime_q    <= UNKNOWN;
      cnt_q       <= '0;
      sig_valid_q <= 1'b0;
      sig_side_q  <= 1'b0;
      sig_price_q <= '0;
      dropped_q   <= '0;
    end else begin
      regime_q  <= regime_d;
      dropped_q <= dropped_d;
      unique case (state_q)
        trade_pkg::IDLE: begin
          if (regime_d != UNKNOWN) state_q <= trade_pkg::TRACK;
        end
        trade_pkg::TRACK: begin
          if (crossing && var_ok) begin
            sig_valid_q <= 1'b1;
            sig_side_q  <= (regime_d == ABOVE) ? SIDE_BUY : SIDE_SELL;
            sig_price_q <= price_q;
            state_q     <= trade_pkg::EMIT;
          end
        end
        trade_pkg::EMIT: begin
          if (xfer) begin
            sig_valid_q <= 1'b0;
            if (COOLDOWN == 0) begin
              state_q <= trade_pkg::TRACK;
            end else begin
              state_q <= trade_pkg::COOLDOWN;
              cnt_q   <= CW'(COOLDOWN);
            end
          end
        end
        trade_pkg::COOLDOWN: begin
          // Only real samples age the cooldown; idle cycles leave it untouched.
          if (s1_vld_q) begin
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q <= CW'(1)) state_q <= trade_pkg::TRACK;
          end
        end
        default: state_q <= trade_pkg::IDLE;
      endcase
    end
  end

  assign sig_valid   = sig_valid_q;
  assign sig_side    = sig_side_q;
  assign sig_price   = sig_price_q;
  assign dropped_cnt = dropped_q;

endmodule

// File: tb/tb_crossover_signal_gen.sv
// Scenario bench for crossover_signal_gen: expected events queue up as stimulus is driven and are
// compared on each handshake; counters and hold behaviour are checked inline per scenario.
module tb_crossover_signal_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  sma_fast = 8'd0;
  logic [7:0]  sma_slow = 8'd100;
  logic [15:0] sqr_mean = 16'd10000;
  logic [7:0]  price = 8'd0;
  logic        sig_ready = 1'b0;
  logic        sig_valid, sig_side;
  logic [7:0]  sig_price, dropped_cnt;

  typedef struct packed {
    logic       side;
    logic [7:0] price;
  } ev_t;

  ev_t sb[$];
  ev_t mon_ev;
  int  errors = 0;
  int  checks = 0;
  int  n_xfer = 0;

  always #5 clk = ~clk;

  crossover_signal_gen #(
    .DATA_WIDTH (8),
    .VAR_WIDTH  (16),
    .HYST       (2),
    .COOLDOWN   (4),
    .VOL_LIMIT  (16'h0400)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .sma_fast    (sma_fast),
    .sma_slow    (sma_slow),
    .sqr_mean    (sqr_mean),
    .price       (price),
    .sig_valid   (sig_valid),
    .sig_ready   (sig_ready),
    .sig_side    (sig_side),
    .sig_price   (sig_price),
    .dropped_cnt (dropped_cnt)
  );

  // Handshake monitor: every transfer must match the oldest expected event.
  always @(negedge clk) begin
    if (rst && sig_valid && sig_ready) begin
      n_xfer++;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: side=%0d price=%0d, no event expected", sig_side, sig_price);
      end else begin
        mon_ev = sb.pop_front();
        if ({sig_side, sig_price} !== {mon_ev.side, mon_ev.price}) begin
          errors++;
          $display("FAIL event_data: side=%0d price=%0d, expected side=%0d price=%0d",
                   sig_side, sig_price, mon_ev.side, mon_ev.price);
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b0;
    in_valid = 1'b0;
    sig_ready = 1'b0;
    sma_slow = 8'd100;
    sqr_mean = 16'd10000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    sb.delete();
    rst = 1'b1;
  endtask

  task automatic drive(input logic [7:0] f, input logic [7:0] p = 8'd0, input logic [15:0] q = 16'd10000);
    @(posedge clk);
    #1;
    sma_fast = f;
    price = p;
    sqr_mean = q;
    in_valid = 1'b1;
  endtask

  task automatic stop();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push(input logic side, input logic [7:0] p);
    ev_t e;
    e.side = side;
    e.price = p;
    sb.push_back(e);
  endtask

  task automatic wait_sig(input logic lvl, input string name);
    int n = 0;
    @(negedge clk);
    while (sig_valid !== lvl && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sig_valid !== lvl) begin
      errors++;
      $display("FAIL %s: sig_valid=%b after %0d cycles, wanted %b", name, sig_valid, n, lvl);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    @(negedge clk);
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d events still outstanding, wanted 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    in_valid = 1'b1;
    sma_fast = 8'd90;
    price = 8'd7;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({sig_valid, sig_side, sig_price, dropped_cnt} !== 18'h0) begin
      errors++;
      $display("FAIL reset_state: valid=%b side=%b price=%0d dropped=%0d, wanted all 0",
               sig_valid, sig_side, sig_price, dropped_cnt);
    end
    do_reset();
  endtask

  task automatic test_warmup();
    do_reset();
    drive(8'd100);
    drive(8'd103);
    drive(8'd97, 8'd55);
    push(1'b0, 8'd55);
    stop();
    @(negedge clk);
    checks++;
    if (sig_valid !== 1'b0) begin
      errors++;
      $display("FAIL warmup_early: sig_valid=%b one edge after sample, wanted 0", sig_valid);
    end
    @(negedge clk);
    checks++;
    if ({sig_valid, sig_side, sig_price} !== {1'b1, 1'b0, 8'd55}) begin
      errors++;
      $display("FAIL warmup_latency: valid=%b side=%b price=%0d, wanted 1 0 55", sig_valid, sig_side, sig_price);
    end
    @(posedge clk);
    #1;
    sig_ready = 1'b1;
    wait_drain("warmup_drain");
    @(negedge clk);
    checks++;
    if (sig_valid !== 1'b0 || dropped_cnt !== 8'd0) begin
      errors++;
      $display("FAIL warmup_after: valid=%b dropped=%0d, wanted 0 0", sig_valid, dropped_cnt);
    end
  endtask

  task automatic test_hysteresis();
    logic [7:0] pat[6] = '{8'd101, 8'd99, 8'd101, 8'd99, 8'd101, 8'd99};
    do_reset();
    sig_ready = 1'b1;
    drive(8'd103);
    for (int i = 0; i < 6; i++) begin
      drive(pat[i], 8'd5);
      @(negedge clk);
      checks++;
      if (sig_valid !== 1'b0) begin
        errors++;
        $display("FAIL hyst_no_signal[%0d]: sig_valid=%b, wanted 0", i, sig_valid);
      end
    end
    stop();
    repeat (3) @(negedge clk);
    checks++;
    if (sig_valid !== 1'b0 || dropped_cnt !== 8'd0) begin
      errors++;
      $display("FAIL hyst_quiet: valid=%b dropped=%0d, wanted 0 0", sig_valid, dropped_cnt);
    end
    drive(8'd98, 8'd77);
    push(1'b0, 8'd77);
    stop();
    wait_sig(1'b1, "hyst_edge_event");
    wait_drain("hyst_drain");
  endtask

  task automatic test_backpressure();
    int x0;
    do_reset();
    drive(8'd103);
    drive(8'd97, 8'd66);
    push(1'b0, 8'd66);
    stop();
    wait_sig(1'b1, "bp_rise");
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      in_valid = (i == 2);
      sma_fast = 8'd104;
      price = 8'd99;
      @(negedge clk);
      checks++;
      if ({sig_valid, sig_side, sig_price} !== {1'b1, 1'b0, 8'd66}) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b side=%b price=%0d, wanted 1 0 66", i, sig_valid, sig_side, sig_price);
      end
    end
    checks++;
    if (dropped_cnt !== 8'd1) begin
      errors++;
      $display("FAIL bp_dropped: dropped=%0d, wanted 1", dropped_cnt);
    end
    x0 = n_xfer;
    @(posedge clk);
    #1;
    sig_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sig_valid !== 1'b0 || n_xfer != x0 + 1) begin
      errors++;
      $display("FAIL bp_single_xfer: valid=%b transfers=%0d, wanted 0 and %0d", sig_valid, n_xfer, x0 + 1);
    end
  endtask

  task automatic test_cooldown();
    do_reset();
    sig_ready = 1'b1;
    drive(8'd103);
    drive(8'd97, 8'd11);
    push(1'b0, 8'd11);
    stop();
    wait_sig(1'b1, "cd_first_rise");
    wait_sig(1'b0, "cd_first_fall");
    drive(8'd100);
    stop();
    repeat (5) @(posedge clk);
    drive(8'd103);
    drive(8'd97);
    drive(8'd100);
    drive(8'd103, 8'd22);
    push(1'b1, 8'd22);
    stop();
    wait_drain("cd_second_event");
    checks++;
    if (dropped_cnt !== 8'd2) begin
      errors++;
      $display("FAIL cd_dropped: dropped=%0d, wanted 2", dropped_cnt);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    sig_ready = 1'b1;
    drive(8'd103);
    drive(8'd97, 8'd33);
    push(1'b0, 8'd33);
    drive(8'd104);
    stop();
    wait_drain("b2b_event");
    repeat (2) @(negedge clk);
    checks++;
    if (dropped_cnt !== 8'd1) begin
      errors++;
      $display("FAIL b2b_collision_drop: dropped=%0d, wanted 1", dropped_cnt);
    end
    drive(8'd97);
    stop();
    repeat (3) @(negedge clk);
    checks++;
    if (dropped_cnt !== 8'd2 || sig_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_in_cooldown: dropped=%0d valid=%b, wanted 2 0", dropped_cnt, sig_valid);
    end
  endtask

  task automatic test_two_flips();
    do_reset();
    drive(8'd103);
    drive(8'd97, 8'd50);
    push(1'b0, 8'd50);
    stop();
    wait_sig(1'b1, "flip_rise");
    drive(8'd104);
    drive(8'd96);
    stop();
    repeat (3) @(negedge clk);
    checks++;
    if (dropped_cnt !== 8'd2 || {sig_valid, sig_side, sig_price} !== {1'b1, 1'b0, 8'd50}) begin
      errors++;
      $display("FAIL flip_count: dropped=%0d valid=%b side=%b price=%0d, wanted 2 1 0 50",
               dropped_cnt, sig_valid, sig_side, sig_price);
    end
    @(posedge clk);
    #1;
    sig_ready = 1'b1;
    wait_drain("flip_drain");
    wait_sig(1'b0, "flip_fall");
    repeat (4) drive(8'd96);
    drive(8'd104, 8'd60);
    push(1'b1, 8'd60);
    stop();
    wait_drain("flip_final_regime");
    checks++;
    if (dropped_cnt !== 8'd2) begin
      errors++;
      $display("FAIL flip_no_extra_drop: dropped=%0d, wanted 2", dropped_cnt);
    end
  endtask

  task automatic test_volatility();
    do_reset();
    sig_ready = 1'b1;
    drive(8'd103, 8'd0, 16'd11100);
    drive(8'd97, 8'd0, 16'd11100);
    drive(8'd103, 8'd44, 16'd11024);
    push(1'b1, 8'd44);
    stop();
    wait_drain("vol_limit_equal");
    wait_sig(1'b0, "vol_fall");
    checks++;
    if (dropped_cnt !== 8'd1) begin
      errors++;
      $display("FAIL vol_drop: dropped=%0d, wanted 1", dropped_cnt);
    end
    repeat (4) drive(8'd103, 8'd0, 16'd9000);
    drive(8'd97, 8'd45, 16'd9000);
    push(1'b0, 8'd45);
    stop();
    wait_drain("vol_clamp_pass");
    checks++;
    if (dropped_cnt !== 8'd1) begin
      errors++;
      $display("FAIL vol_clamp_drop: dropped=%0d, wanted 1", dropped_cnt);
    end
  endtask

  task automatic test_reset_mid_emit();
    do_reset();
    drive(8'd103);
    drive(8'd97, 8'd88);
    push(1'b0, 8'd88);
    drive(8'd104);
    stop();
    wait_sig(1'b1, "rme_rise");
    @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checks++;
    if ({sig_valid, sig_side, sig_price, dropped_cnt} !== 18'h0) begin
      errors++;
      $display("FAIL rme_async_clear: valid=%b side=%b price=%0d dropped=%0d, wanted all 0",
               sig_valid, sig_side, sig_price, dropped_cnt);
    end
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    sig_ready = 1'b1;
    drive(8'd96);
    stop();
    repeat (3) @(negedge clk);
    checks++;
    if (sig_valid !== 1'b0) begin
      errors++;
      $display("FAIL rme_idle_entry: sig_valid=%b, wanted 0", sig_valid);
    end
    drive(8'd104, 8'd89);
    push(1'b1, 8'd89);
    stop();
    wait_drain("rme_track_event");
  endtask

  task automatic test_saturation();
    do_reset();
    sig_ready = 1'b1;
    drive(8'd103, 8'd0, 16'hFFFF);
    for (int i = 0; i < 300; i++) drive((i % 2 == 0) ? 8'd97 : 8'd103, 8'd0, 16'hFFFF);
    stop();
    repeat (3) @(negedge clk);
    checks++;
    if (dropped_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL sat_dropped: dropped=%0d, wanted 255", dropped_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_warmup();
    test_hysteresis();
    test_backpressure();
    test_cooldown();
    test_back_to_back();
    test_two_flips();
    test_volatility();
    test_reset_mid_emit();
    test_saturation();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL final_scoreboard: %0d events never seen, wanted 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
